// File: rtl/dma_mc_controller.sv
// Multi-channel DMA engine: round-robin arbitration of NUM_CH device channels onto one memory port.
// One staging register carries each word; grants are capped at BURST_LEN words before re-arbitration.
module dma_mc_controller #(
  parameter int ADD_LEN   = 16,
  parameter int DATA_LEN  = 16,
  parameter int NUM_CH    = 2,
  parameter int BURST_LEN = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_CH-1:0]            ch_rqst,
  input  logic [NUM_CH-1:0]            ch_rd_wr,
  input  logic [NUM_CH*ADD_LEN-1:0]    ch_num_words,
  input  logic [NUM_CH*ADD_LEN-1:0]    ch_start_addr,
  input  logic [NUM_CH-1:0]            ch_dev_ack,
  input  logic [NUM_CH*DATA_LEN-1:0]   ch_dev_in,
  output logic [NUM_CH-1:0]            ch_dma_ack,
  output logic [DATA_LEN-1:0]          dev_out,
  output logic [NUM_CH-1:0]            ch_busy,
  output logic [NUM_CH-1:0]            ch_end_flag,
  output logic [NUM_CH-1:0]            ch_error,
  output logic [ADD_LEN-1:0]           dma_addr,
  output logic [DATA_LEN-1:0]          dma_out,
  output logic                         dma_en,
  output logic [1:0]                   dma_we,
  output logic                         dma_priority,
  input  logic [DATA_LEN-1:0]          dma_in,
  input  logic                         dma_ready,
  input  logic                         dma_resp
);

  localparam int CH_W = $clog2(NUM_CH);
  localparam int BW   = $clog2(BURST_LEN + 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ARB   = 3'd1;
  localparam logic [2:0] MEM   = 3'd2;
  localparam logic [2:0] RDATA = 3'd3;
  localparam logic [2:0] DEV   = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;

  logic [2:0]          state;
  logic [NUM_CH-1:0]   busy;
  logic [NUM_CH-1:0]   dir;
  logic [NUM_CH-1:0]   zero_flag;
  logic [ADD_LEN-1:0]  addr [NUM_CH];
  logic [ADD_LEN-1:0]  remaining [NUM_CH];
  logic [CH_W-1:0]     grant;
  logic [CH_W-1:0]     ptr;
  logic [BW-1:0]       burst;
  logic                err;
  logic [DATA_LEN-1:0] stage;

  logic [CH_W-1:0]     grant_next;
  logic [CH_W-1:0]     hi_idx;
  logic [CH_W-1:0]     lo_idx;
  logic                hi_found;
  logic [NUM_CH-1:0]   grant_oh;
  logic                other_busy;
  logic [BW-1:0]       burst_inc;
  logic                burst_full;
  logic                last_word;
  logic                update;
  logic [2:0]          update_state;
  logic [BW-1:0]       update_burst;

  // Prefer the lowest busy channel at or above ptr, else wrap to the lowest busy channel.
  always_comb begin
    hi_idx   = '0;
    lo_idx   = '0;
    hi_found = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (busy[i]) begin
        lo_idx = CH_W'(i);
        if (CH_W'(i) >= ptr) begin
          hi_idx   = CH_W'(i);
          hi_found = 1'b1;
        end
      end
    end
    grant_next = hi_found ? hi_idx : lo_idx;
  end

  assign grant_oh   = NUM_CH'(1) << grant;
  assign other_busy = |(busy & ~grant_oh);
  assign burst_inc  = burst + BW'(1);
  assign burst_full = (burst_inc == BW'(BURST_LEN));
  assign last_word  = (remaining[grant] == ADD_LEN'(1));

  assign update = ((state == MEM) && dma_ready && !dma_resp && !dir[grant]) ||
                  ((state == DEV) && ch_dev_ack[grant] && dir[grant]);

  // A full burst only yields when someone else is waiting; otherwise the grant just continues.
  always_comb begin
    update_burst = burst_full ? '0 : burst_inc;
    if (last_word)
      update_state = DONE;
    else if (burst_full && other_busy)
      update_state = ARB;
    else
      update_state = dir[grant] ? MEM : DEV;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= '0;
      dir       <= '0;
      zero_flag <= '0;
      grant     <= '0;
      ptr       <= '0;
      burst     <= '0;
      err       <= 1'b0;
      stage     <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        addr[i]      <= '0;
        remaining[i] <= '0;
      end
    end else begin
      zero_flag <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_rqst[i] && !busy[i]) begin
          dir[i]       <= ch_rd_wr[i];
          addr[i]      <= ch_start_addr[i*ADD_LEN +: ADD_LEN];
          remaining[i] <= ch_num_words[i*ADD_LEN +: ADD_LEN];
          if (ch_num_words[i*ADD_LEN +: ADD_LEN] == '0)
            zero_flag[i] <= 1'b1;
          else
            busy[i] <= 1'b1;
        end
      end

      if (update) begin
        addr[grant]      <= addr[grant] + ADD_LEN'(1);
        remaining[grant] <= remaining[grant] - ADD_LEN'(1);
      end

      case (state)
        IDLE: if (|busy) state <= ARB;
        ARB: begin
          grant <= grant_next;
          ptr   <= (grant_next == CH_W'(NUM_CH - 1)) ? '0 : grant_next + CH_W'(1);
          burst <= '0;
          err   <= 1'b0;
          state <= dir[grant_next] ? MEM : DEV;
        end
        MEM: begin
          if (dma_ready) begin
            if (dma_resp) begin
              err   <= 1'b1;
              state <= DONE;
            end else if (dir[grant]) begin
              state <= RDATA;
            end else begin
              state <= update_state;
              burst <= update_burst;
            end
          end
        end
        RDATA: begin
          stage <= dma_in;
          state <= DEV;
        end
        DEV: begin
          if (ch_dev_ack[grant]) begin
            if (dir[grant]) begin
              state <= update_state;
              burst <= update_burst;
            end else begin
              stage <= ch_dev_in[grant*DATA_LEN +: DATA_LEN];
              state <= MEM;
            end
          end
        end
        DONE: begin
          busy[grant] <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ch_busy      = busy;
  assign ch_end_flag  = zero_flag | ((state == DONE) ? grant_oh : '0);
  assign ch_error     = (state == DONE && err) ? grant_oh : '0;
  assign ch_dma_ack   = (state == DEV) ? grant_oh : '0;
  assign dma_en       = (state == MEM);
  assign dma_addr     = (state == MEM) ? addr[grant] : '0;
  assign dma_we       = (state == MEM && !dir[grant]) ? 2'b11 : 2'b00;
  assign dma_priority = 1'b0;
  assign dev_out      = stage;
  assign dma_out      = stage;

endmodule

// File: tb/tb_dma_mc_controller.sv
// Bench for dma_mc_controller: memory/device responders feed scoreboard queues of expected accesses.
module tb_dma_mc_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  ch_rqst, ch_rd_wr, ch_dev_ack, ch_dma_ack, ch_busy, ch_end_flag, ch_error;
  logic [31:0] ch_num_words, ch_start_addr, ch_dev_in;
  logic [15:0] dev_out, dma_addr, dma_out, dma_in;
  logic        dma_en, dma_priority, dma_ready, dma_resp;
  logic [1:0]  dma_we;

  dma_mc_controller dut (
    .clk(clk), .reset(reset), .ch_rqst(ch_rqst), .ch_rd_wr(ch_rd_wr),
    .ch_num_words(ch_num_words), .ch_start_addr(ch_start_addr),
    .ch_dev_ack(ch_dev_ack), .ch_dev_in(ch_dev_in), .ch_dma_ack(ch_dma_ack),
    .dev_out(dev_out), .ch_busy(ch_busy), .ch_end_flag(ch_end_flag), .ch_error(ch_error),
    .dma_addr(dma_addr), .dma_out(dma_out), .dma_en(dma_en), .dma_we(dma_we),
    .dma_priority(dma_priority), .dma_in(dma_in), .dma_ready(dma_ready), .dma_resp(dma_resp)
  );

  always #5 clk = ~clk;

  typedef struct { logic [15:0] addr; logic [1:0] we; logic [15:0] data; } mem_exp_t;
  typedef struct { int ch; bit rd; logic [15:0] data; } dev_exp_t;
  typedef struct { int ch; bit rd; logic [15:0] addr; int n; int stall; int exp_acc; int exp_end; } vec_t;

  mem_exp_t mem_q[$];
  dev_exp_t dev_q[$];

  int checks = 0, failures = 0;
  int cyc = 0, rq_cyc = 0, last_hs = 0;
  int acc_cnt, en_cnt, resp_at, mem_stall, dev_stall;
  int end_cnt[2], err_cnt[2], end_cyc[2], dev_k[2];
  int overlap_err = 0, stable_err = 0, coin_err = 0;
  bit pend_rd = 0, stall_prev = 0;
  logic [15:0] pend_addr, stall_addr;

  function automatic logic [15:0] mem_val(input logic [15:0] a);
    return a ^ 16'h01A0;
  endfunction

  function automatic logic [15:0] wr_val(input int k);
    return 16'h0055 + 16'(k) * 16'h0011;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Memory and device responders; every handshake is compared against the scoreboard.
  always @(negedge clk) begin
    mem_exp_t me;
    dev_exp_t de;
    if (reset) begin
      dma_ready = 0; dma_resp = 0; ch_dev_ack = '0; pend_rd = 0; stall_prev = 0;
    end else begin
      dma_in = pend_rd ? mem_val(pend_addr) : 16'hDEAD;
      pend_rd = 0;
      if (dma_en && ch_dma_ack != 2'b00) overlap_err++;
      if (dma_priority) overlap_err++;
      if (stall_prev && dma_en && dma_addr != stall_addr) stable_err++;
      stall_prev = 0;
      if (dma_en) en_cnt++;
      dma_ready = 0;
      dma_resp = 0;
      if (dma_en) begin
        if (mem_stall > 0) begin
          mem_stall--;
          dma_resp = 1;
          stall_prev = 1;
          stall_addr = dma_addr;
        end else begin
          dma_ready = 1;
          dma_resp = (acc_cnt == resp_at);
          acc_cnt++;
          last_hs = cyc;
          if (mem_q.size() == 0) chk("mem_unexpected", {16'h0, dma_addr}, 32'hFFFF_FFFF);
          else begin
            me = mem_q.pop_front();
            chk("mem_addr", dma_addr, me.addr);
            chk("mem_we", dma_we, me.we);
            if (me.we == 2'b11) chk("mem_wdata", dma_out, me.data);
          end
          if (dma_we == 2'b00 && !dma_resp) begin pend_rd = 1; pend_addr = dma_addr; end
        end
      end
      ch_dev_ack = '0;
      for (int c = 0; c < 2; c++) begin
        if (ch_dma_ack[c]) begin
          if (dev_stall > 0) dev_stall--;
          else begin
            ch_dev_ack[c] = 1'b1;
            ch_dev_in[c*16 +: 16] = wr_val(dev_k[c]);
            dev_k[c]++;
            last_hs = cyc;
            if (dev_q.size() == 0) chk("dev_unexpected", c, 32'hFFFF_FFFF);
            else begin
              de = dev_q.pop_front();
              chk("dev_ch", c, de.ch);
              if (de.rd) chk("dev_rdata", dev_out, de.data);
            end
          end
        end
        if (ch_end_flag[c]) begin end_cnt[c]++; end_cyc[c] = cyc; end
        if (ch_error[c]) err_cnt[c]++;
        if (ch_error[c] && !ch_end_flag[c]) coin_err++;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear();
    acc_cnt = 0; en_cnt = 0; resp_at = -1; mem_stall = 0; dev_stall = 0; last_hs = 0;
    for (int c = 0; c < 2; c++) begin end_cnt[c] = 0; err_cnt[c] = 0; end_cyc[c] = 0; dev_k[c] = 0; end
  endtask

  task automatic do_reset();
    reset = 1; ch_rqst = '0;
    repeat (2) @(posedge clk);
    step();
    reset = 0;
    clear();
  endtask

  task automatic set_ch(input int c, input bit rd, input logic [15:0] a, input logic [15:0] n);
    ch_rd_wr[c] = rd;
    ch_start_addr[c*16 +: 16] = a;
    ch_num_words[c*16 +: 16] = n;
  endtask

  task automatic pulse(input logic [1:0] mask);
    rq_cyc = cyc;
    ch_rqst = mask;
    step();
    ch_rqst = '0;
  endtask

  task automatic push_xfer(input int c, input bit rd, input logic [15:0] a, input int k0, input int cnt);
    logic [15:0] wa;
    for (int k = k0; k < k0 + cnt; k++) begin
      wa = a + 16'(k);
      if (rd) begin
        mem_q.push_back('{wa, 2'b00, 16'h0000});
        dev_q.push_back('{c, 1'b1, mem_val(wa)});
      end else begin
        dev_q.push_back('{c, 1'b0, 16'h0000});
        mem_q.push_back('{wa, 2'b11, wr_val(k)});
      end
    end
  endtask

  task automatic wait_end(input int c, input int target);
    int t = 0;
    while (end_cnt[c] < target && t < 400) begin step(); t++; end
    chk($sformatf("end_timeout_ch%0d", c), (end_cnt[c] >= target), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    vecs[0] = '{0, 1'b1, 16'h0100, 3, 0, 3, 1};
    vecs[1] = '{1, 1'b0, 16'h0200, 2, 2, 2, 1};
    vecs[2] = '{0, 1'b1, 16'hFFFF, 2, 0, 2, 1};
    vecs[3] = '{1, 1'b1, 16'h0050, 5, 1, 5, 1};
    vecs[4] = '{0, 1'b0, 16'h1234, 0, 0, 0, 1};
    vecs[5] = '{1, 1'b0, 16'h0010, 6, 0, 6, 1};

    ch_rqst = '0; ch_rd_wr = '0; ch_num_words = '0; ch_start_addr = '0; ch_dev_in = '0;
    ch_dev_ack = '0; dma_in = '0; dma_ready = 0; dma_resp = 0;
    clear();
    do_reset();
    chk("rst_busy", ch_busy, 0);
    chk("rst_end", ch_end_flag, 0);
    chk("rst_err", ch_error, 0);
    chk("rst_en", dma_en, 0);
    chk("rst_addr", dma_addr, 0);
    chk("rst_we", dma_we, 0);
    chk("rst_stage", {dev_out, dma_out}, 0);
    chk("rst_ack", ch_dma_ack, 0);

    foreach (vecs[i]) begin
      clear();
      mem_stall = vecs[i].stall;
      push_xfer(vecs[i].ch, vecs[i].rd, vecs[i].addr, 0, vecs[i].n);
      set_ch(vecs[i].ch, vecs[i].rd, vecs[i].addr, 16'(vecs[i].n));
      pulse(2'b01 << vecs[i].ch);
      wait_end(vecs[i].ch, 1);
      step(); step();
      chk($sformatf("v%0d_end_cnt", i), end_cnt[vecs[i].ch], vecs[i].exp_end);
      chk($sformatf("v%0d_acc_cnt", i), acc_cnt, vecs[i].exp_acc);
      chk($sformatf("v%0d_err", i), err_cnt[vecs[i].ch], 0);
      chk($sformatf("v%0d_memq", i), mem_q.size(), 0);
      chk($sformatf("v%0d_devq", i), dev_q.size(), 0);
      chk($sformatf("v%0d_end_cyc", i), end_cyc[vecs[i].ch], ((vecs[i].n == 0) ? rq_cyc : last_hs) + 1);
      chk($sformatf("v%0d_busy", i), ch_busy, 0);
      if (vecs[i].n == 0) chk($sformatf("v%0d_no_en", i), en_cnt, 0);
    end

    // Round robin: both channels read 6 words, bursts of 4 interleave.
    do_reset();
    push_xfer(0, 1, 16'h1000, 0, 4);
    push_xfer(1, 1, 16'h2000, 0, 4);
    push_xfer(0, 1, 16'h1000, 4, 2);
    push_xfer(1, 1, 16'h2000, 4, 2);
    set_ch(0, 1, 16'h1000, 6);
    set_ch(1, 1, 16'h2000, 6);
    pulse(2'b11);
    wait_end(1, 1);
    step(); step();
    chk("rr_end0", end_cnt[0], 1);
    chk("rr_end1", end_cnt[1], 1);
    chk("rr_order", (end_cyc[0] < end_cyc[1]), 1);
    chk("rr_acc", acc_cnt, 12);
    chk("rr_memq", mem_q.size(), 0);
    chk("rr_devq", dev_q.size(), 0);

    // Zero length on ch0, then a request on busy ch1 that must be ignored.
    clear();
    set_ch(0, 1, 16'h1234, 0);
    pulse(2'b01);
    step(); step();
    chk("zl_end", end_cnt[0], 1);
    chk("zl_no_en", en_cnt, 0);
    chk("zl_busy", ch_busy[0], 0);
    push_xfer(1, 1, 16'h0300, 0, 3);
    dev_stall = 5;
    set_ch(1, 1, 16'h0300, 3);
    pulse(2'b10);
    step();
    chk("bz_busy", ch_busy[1], 1);
    set_ch(1, 0, 16'h0400, 5);
    pulse(2'b10);
    wait_end(1, 1);
    step(); step();
    chk("bz_end", end_cnt[1], 1);
    chk("bz_acc", acc_cnt, 3);
    chk("bz_memq", mem_q.size(), 0);
    chk("bz_devq", dev_q.size(), 0);

    // Error on the second word of a 4-word read.
    clear();
    resp_at = 1;
    mem_q.push_back('{16'h0700, 2'b00, 16'h0000});
    mem_q.push_back('{16'h0701, 2'b00, 16'h0000});
    dev_q.push_back('{0, 1'b1, mem_val(16'h0700)});
    set_ch(0, 1, 16'h0700, 4);
    pulse(2'b01);
    wait_end(0, 1);
    repeat (10) step();
    chk("err_cnt", err_cnt[0], 1);
    chk("err_end", end_cnt[0], 1);
    chk("err_busy", ch_busy, 0);
    chk("err_en_cnt", en_cnt, 2);
    chk("err_memq", mem_q.size(), 0);
    chk("err_devq", dev_q.size(), 0);

    // Reset while stalled in MEM.
    clear();
    mem_stall = 1000;
    set_ch(0, 1, 16'h0800, 2);
    pulse(2'b01);
    for (int t = 0; t < 20 && !dma_en; t++) step();
    chk("rs_in_mem", dma_en, 1);
    chk("rs_addr_pre", dma_addr, 16'h0800);
    #2 reset = 1;
    #1;
    chk("rs_en", dma_en, 0);
    chk("rs_addr", dma_addr, 0);
    chk("rs_busy", ch_busy, 0);
    chk("rs_stage", {dev_out, dma_out}, 0);
    chk("rs_flags", {ch_end_flag, ch_error, ch_dma_ack, dma_we}, 0);
    repeat (3) step();
    reset = 0;
    mem_stall = 0;
    step(); step();
    chk("rs_no_end", end_cnt[0] + err_cnt[0], 0);
    chk("rs_idle", {ch_busy, dma_en}, 0);

    chk("overlap_viol", overlap_err, 0);
    chk("addr_stable_viol", stable_err, 0);
    chk("err_coincident_viol", coin_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dma_mc_controller.md
# dma_mc_controller

Multi-channel successor to the single-channel DMA engine. It serves NUM_CH independent device channels through one shared openMSP430 DMA memory port. Busy channels are picked by a round-robin arbiter, and each grant lasts at most BURST_LEN words. It adds per-channel error reporting, re-arbitration mid-transfer, and zero-length rejection without a FIFO. One staging register holds each word in flight.

## Interface
- ADD_LEN, 16, word-address width of memory port and counters
- DATA_LEN, 16, data width
- NUM_CH, 2, number of device channels (≥2)
- BURST_LEN, 4, max words per grant before re-arbitration (≥1)
- CH_W, $clog2(NUM_CH), grant index width (local)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- ch_rqst  in  NUM_CH  per-channel start pulse
- ch_rd_wr  in  NUM_CH  1 = memory→device, 0 = device→memory; sampled with rqst
- ch_num_words  in  NUM_CH*ADD_LEN  word count, channel i at [i*ADD_LEN +: ADD_LEN]
- ch_start_addr  in  NUM_CH*ADD_LEN  start word address, same packing
- ch_dev_ack  in  NUM_CH  device ready (read) / data valid (write)
- ch_dev_in  in  NUM_CH*DATA_LEN  device write data
- ch_dma_ack  out  NUM_CH  controller data valid (read) / ready (write)
- dev_out  out  DATA_LEN  staging register, broadcast to all channels
- ch_busy  out  NUM_CH  channel has an accepted, unfinished transfer
- ch_end_flag  out  NUM_CH  1-cycle pulse when a transfer completes
- ch_error  out  NUM_CH  1-cycle pulse, coincident with ch_end_flag, on abort
- dma_addr  out  ADD_LEN  memory word address, 0 when not in MEM
- dma_out  out  DATA_LEN  staging register
- dma_en  out  1  memory access request
- dma_we  out  2  2'b11 on write access, else 2'b00
- dma_priority  out  1  constant 0
- dma_in  in  DATA_LEN  memory read data, valid the cycle after dma_ready
- dma_ready  in  1  access accepted this cycle
- dma_resp  in  1  access error, qualified by dma_ready

## Operation
- Per-channel context registers: busy, dir, addr, remaining (ADD_LEN bits).
- Channel i accepts ch_rqst[i] only when busy[i] = 0. On acceptance it latches dir, addr and remaining.
- If num_words = 0 at acceptance, the channel does not go busy. ch_end_flag[i] pulses the next cycle and there is no memory access.
- ch_rqst while busy is ignored. Context and the running transfer are unchanged.
- Engine FSM states: IDLE, ARB, MEM, RDATA, DEV, DONE.
- IDLE: if any busy → ARB.
- ARB: 1 cycle. Grant the first busy channel searching from ptr, where ptr = last grant + 1 mod NUM_CH and ptr = 0 after reset. Clear the burst counter. Go to MEM if dir = read, DEV if write.
- MEM: dma_en = 1, dma_addr = addr[g], dma_we = 11 for writes. Hold until dma_ready.
  - dma_ready & dma_resp → DONE with error.
  - read → RDATA.
  - write → update, then next.
- RDATA: capture dma_in into staging → DEV.
- DEV: ch_dma_ack[g] = 1. Hold until ch_dev_ack[g].
  - read: word accepted, then update and next.
  - write: capture ch_dev_in[g] into staging → MEM.
- Update: addr += 1, wrapping mod 2^ADD_LEN. remaining −= 1. burst += 1.
- Next decision:
  - remaining becomes 0 → DONE.
  - burst = BURST_LEN and another channel busy → ARB.
  - burst = BURST_LEN and no other channel busy → continue, burst cleared.
  - otherwise → MEM (read) or DEV (write).
- DONE: 1 cycle. ch_end_flag[g] = 1, ch_error[g] = error, busy[g] cleared → IDLE.
- A preempted channel keeps addr and remaining and resumes exactly at the next word on its next grant.

## Timing
- Reset: all outputs 0, all busy 0, FSM IDLE, ptr 0. Reset mid-transfer discards all contexts with no end_flag or error pulse.
- Acceptance: ch_busy rises the cycle after ch_rqst. ARB is at earliest the cycle after that.
- Read word, zero wait states: MEM, RDATA, DEV = 3 cycles/word. Write word: DEV, MEM = 2 cycles/word.
- A rqst on channel i in the same cycle as its DONE is ignored, because busy is still 1.
- Simultaneous ch_rqst on several idle channels: all are accepted. Grant order follows ptr.
- dma_resp without dma_ready is ignored.
- ch_dma_ack and dma_en are never both high.

## Test plan
- Single read: ch0 rd, addr 0x0100, 3 words, memory returns 0xA0,0xA1,0xA2, dev_ack held 1 → dma_addr 0x100,0x101,0x102. dev_out sequence A0,A1,A2. ch_end_flag[0] one cycle after the third handshake. ch_error stays 0.
- Write with backpressure: ch1 wr, addr 0x0200, 2 words, ch_dev_in 0x55 then 0x66, dma_ready low for 2 cycles on first access → writes 0x55→0x200 and 0x66→0x201 with dma_we = 11. dma_addr is stable while stalled.
- Round robin: ch0 and ch1 both read 6 words, BURST_LEN 4 → grant order ch0 ×4, ch1 ×4, ch0 ×2, ch1 ×2. Addresses continue correctly after preemption.
- Zero length and busy: ch0 num_words = 0 → end_flag pulses with no dma_en. A second rqst on ch1 while busy is ignored, and the original transfer completes unchanged.
- Error: dma_resp = 1 with dma_ready on the 2nd word of a 4-word read → ch_error and ch_end_flag pulse together. busy clears and no further dma_en occurs.
- Wrap and reset: start addr 0xFFFF, 2 words → dma_addr 0xFFFF then 0x0000. A reset asserted during MEM drives all outputs to 0 immediately, with no end_flag.
